double_mult_arbiter: RTL

DOUBLE_MULT_ARBITER -- requirements
Module: double_mult_arbiter

---
 rtl/double_mult_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/double_mult_arbiter.sv
// rtl/double_mult_arbiter.sv - round-robin arbiter sharing one double multiplier, results returned in issue order
// Optional feature macro: DOUBLE_MULT_ARB_STATS_EN enables the stat_issue_count counter.
module double_mult_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_tvalid,
    input  logic [64*NUM_REQ-1:0] req_a_tdata,
    input  logic [64*NUM_REQ-1:0] req_b_tdata,
    output logic [NUM_REQ-1:0]    req_tready,
    output logic [NUM_REQ-1:0]    rsp_tvalid,
    output logic [63:0]           rsp_tdata,
    input  logic [NUM_REQ-1:0]    rsp_tready,
    output logic                  mul_a_tvalid,
    output logic [63:0]           mul_a_tdata,
    input  logic                  mul_a_tready,
    output logic                  mul_b_tvalid,
    output logic [63:0]           mul_b_tdata,
    input  logic                  mul_b_tready,
    input  logic                  mul_result_tvalid,
    input  logic [63:0]           mul_result_tdata,
    output logic                  busy,
    output logic                  err_orphan,
    output logic [31:0]           stat_issue_count
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] grant;
    logic             any_req;
    int               idx;
    logic [CNT_W-1:0] outstanding;
    logic             issue;

    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tag_wr;
    logic [PTR_W-1:0] tag_rd;
    logic [CNT_W-1:0] tag_cnt;
    logic             tag_pop;
    logic             orphan;

    logic [TAG_W-1:0] res_tag_mem  [FIFO_DEPTH];
    logic [63:0]      res_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] res_wr;
    logic [PTR_W-1:0] res_rd;
    logic [CNT_W-1:0] res_cnt;
    logic             res_valid;
    logic             res_pop;
    logic [TAG_W-1:0] head_tag;

    // Scan offsets from the highest down so the nearest requester above rr_ptr wins.
    always_comb begin
        grant   = rr_ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_tvalid[idx]) begin
                grant   = TAG_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign mul_a_tvalid = rst_n & any_req & (outstanding < DEPTH_C);
    assign mul_b_tvalid = mul_a_tvalid;
    assign mul_a_tdata  = req_a_tdata[int'(grant)*64 +: 64];
    assign mul_b_tdata  = req_b_tdata[int'(grant)*64 +: 64];
    assign issue        = mul_a_tvalid & mul_a_tready & mul_b_tready;

    always_comb begin
        req_tready = '0;
        if (issue) begin
            req_tready[grant] = 1'b1;
        end
    end

    // A result with no tag waiting is dropped; it never reaches the result FIFO.
    assign tag_pop = mul_result_tvalid & (tag_cnt != '0);
    assign orphan  = mul_result_tvalid & (tag_cnt == '0);

    assign res_valid = res_cnt != '0;
    assign head_tag  = res_tag_mem[res_rd];
    assign rsp_tdata = res_data_mem[res_rd];
    assign res_pop   = rst_n & res_valid & rsp_tready[head_tag];

    always_comb begin
        rsp_tvalid = '0;
        if (rst_n && res_valid) begin
            rsp_tvalid[head_tag] = 1'b1;
        end
    end

    assign busy = rst_n & (outstanding != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            outstanding <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            tag_cnt     <= '0;
            res_wr      <= '0;
            res_rd      <= '0;
            res_cnt     <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (issue) begin
                rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
                tag_wr <= tag_wr + 1'b1;
            end
            if (tag_pop) begin
                tag_rd <= tag_rd + 1'b1;
                res_wr <= res_wr + 1'b1;
            end
            if (res_pop) begin
                res_rd <= res_rd + 1'b1;
            end
            case ({issue, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            case ({tag_pop, res_pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: res_cnt <= res_cnt;
            endcase
            case ({issue, res_pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (orphan) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Storage arrays need no reset: the pointers and counts define what is live.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[tag_wr] <= grant;
        end
        if (tag_pop) begin
            res_tag_mem[res_wr]  <= tag_mem[tag_rd];
            res_data_mem[res_wr] <= mul_result_tdata;
        end
    end

`ifdef DOUBLE_MULT_ARB_STATS_EN
    logic [31:0] issue_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_count <= '0;
        end else if (issue) begin
            issue_count <= issue_count + 32'd1;
        end
    end

    assign stat_issue_count = issue_count;
`else
    assign stat_issue_count = 32'd0;
`endif

endmodule
